seq_mul: RTL and testbench

SEQ_MUL -- requirements
Module: seq_mul

---
 rtl/seq_mul.sv | 127 ++++++++++++
 tb/tb_seq_mul.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// Shift-and-add unsigned N x N multiplier with a ready/busy/done handshake.
// Optional SEQ_MUL_EARLY_EXIT_EN: zero operands skip RUN and finish in one cycle.
module ADD #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[N];

endmodule

module seq_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  a_q;
  logic [N-1:0]  p_hi;
  logic [N-1:0]  p_lo;
  logic [CW-1:0] cnt;
  logic [N-1:0]  sum;
  logic          c_out;
  logic [N-1:0]  acc;
  logic          carry;
  logic          take;
  logic          skip;

  ADD #(.N(N)) u_add (
    .a     (p_hi),
    .b     (a_q),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  assign ready   = (state == IDLE);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = {p_hi, p_lo};
  assign take    = ready & start;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign skip = (a == '0) || (b == '0);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    acc   = p_hi;
    carry = 1'b0;
    if (p_lo[0]) begin
      acc   = sum;
      carry = c_out;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = skip ? DONE : RUN;
      end
      RUN: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Product lives in {p_hi,p_lo}; it only changes on accept or in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      p_hi <= '0;
      p_lo <= '0;
      cnt  <= '0;
    end else if (take) begin
      a_q  <= a;
      p_hi <= '0;
      p_lo <= skip ? '0 : b;
      cnt  <= CW'(N);
    end else if (busy) begin
      {p_hi, p_lo} <= {carry, acc, p_lo[N-1:1]};
      cnt          <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Randomized self-checking bench for seq_mul at N=8.
// Reference: plain a*b and cycle timing derived from the handshake rules.
module tb_seq_mul;

  localparam int N = 8;
`ifdef SEQ_MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 1'b0;

  seq_mul #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (armed) check("onehot", 32'($countones({ready, busy, done})), 1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mul(input string tag, input logic [N-1:0] x,
                        input logic [N-1:0] y, input int inj);
    int lat;
    int nb;
    int elat;
    logic [2*N-1:0] exp_p;
    exp_p = (2*N)'(x) * (2*N)'(y);
    elat  = (EARLY && (x == 0 || y == 0)) ? 1 : N + 1;
    check({tag, "_rdy0"}, ready, 1);
    start = 1'b1;
    a = x;
    b = y;
    tick();
    start = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    lat = 1;
    nb = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      if (lat == inj) begin
        start = 1'b1;
        a = 9;
        b = 9;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busy"}, nb, elat - 1);
    check({tag, "_prod"}, product, exp_p);
    tick();
    check({tag, "_rdy"}, ready, 1);
    check({tag, "_done1"}, done, 0);
    check({tag, "_hold"}, product, exp_p);
  endtask

  initial begin
    logic [2*N-1:0] q[$];
    logic [2*N-1:0] e;
    int cyc;
    int last_done;
    int pushed;
    int popped;
    int nd;

    rst = 1'b1;
    tick();
    tick();
    armed = 1'b1;
    rst = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);

    do_mul("m13x11", 13, 11, 0);
    do_mul("m255x255", 255, 255, 0);
    do_mul("m5x7", 5, 7, 3);
    do_mul("m9x9", 9, 9, 0);
    do_mul("m0x200", 0, 200, 0);
    do_mul("m200x0", 200, 0, 0);

    // Abort mid-RUN; a start held during reset must be ignored.
    start = 1'b1;
    a = 13;
    b = 11;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    start = 1'b1;
    a = 3;
    b = 3;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_prod", product, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      tick();
    end
    check("abort_nodone", nd, 0);
    check("abort_idle", ready, 1);

    // Back-to-back with start held high.
    cyc = 0;
    last_done = -1;
    pushed = 0;
    popped = 0;
    start = 1'b1;
    while (popped < 100 && cyc < 2000) begin
      if (done) begin
        if (last_done >= 0) check("b2b_gap", cyc - last_done, N + 2);
        last_done = cyc;
        check("b2b_q", (q.size() > 0) ? 1 : 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("b2b_prod", product, e);
          popped++;
        end
      end
      a = N'($urandom_range(1, (1 << N) - 1));
      b = N'($urandom_range(1, (1 << N) - 1));
      if (ready && pushed < 100) begin
        q.push_back((2*N)'(a) * (2*N)'(b));
        pushed++;
      end
      tick();
      if (pushed >= 100) start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    check("b2b_count", popped, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
